// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared definitions for the shift-and-add multiplier and product accumulator
package mac_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } acc_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int prod_width(input int n);
        return 2 * n + 1;
    endfunction

endpackage

// File: rtl/sat_adder_nbit.sv
// rtl/sat_adder_nbit.sv - combinational unsigned saturating adder
module sat_adder_nbit #(
    parameter int W = 20
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

    logic [W:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b};
        sat  = full[W];
        sum  = full[W] ? {W{1'b1}} : full[W-1:0];
    end

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums VEC_LEN multiplier products into a saturating dot-product result
module product_accumulator
    import mac_pkg::*;
#(
    parameter int N       = 8,
    parameter int VEC_LEN = 4,
    parameter int ACC_W   = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic [prod_width(N)-1:0]  in_prod,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [ACC_W-1:0]          out_sum,
    output logic                      out_ovf,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int PW = prod_width(N);
    localparam int CW = clog2(VEC_LEN + 1);

    if (ACC_W < PW) begin : g_bad_acc_w
        $error("product_accumulator: ACC_W must be >= 2*N+1");
    end
    if (VEC_LEN < 1 || VEC_LEN > 255) begin : g_bad_vec_len
        $error("product_accumulator: VEC_LEN must be in 1..255");
    end

    acc_state_t        state, state_n;
    logic [ACC_W-1:0]  acc, acc_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              ovf_r, ovf_n;
    logic [ACC_W-1:0]  out_sum_n;
    logic              out_ovf_n;
    logic              out_valid_n;
    logic [ACC_W-1:0]  add_sum;
    logic              add_sat;

    sat_adder_nbit #(.W(ACC_W)) u_sat_add (
        .a   (acc),
        .b   (ACC_W'(in_prod)),
        .sum (add_sum),
        .sat (add_sat)
    );

    assign in_ready = (state == ST_ACCUM);

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        cnt_n       = cnt;
        ovf_n       = ovf_r;
        out_sum_n   = out_sum;
        out_ovf_n   = out_ovf;
        out_valid_n = out_valid;
        if (clr) begin
            state_n     = ST_ACCUM;
            acc_n       = '0;
            cnt_n       = '0;
            ovf_n       = 1'b0;
            out_valid_n = 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc_n = add_sum;
                        cnt_n = cnt + CW'(1);
                        ovf_n = ovf_r | add_sat;
                        // Final product of the vector: publish the result on the same edge.
                        if (cnt == CW'(VEC_LEN - 1)) begin
                            state_n     = ST_HOLD;
                            out_sum_n   = add_sum;
                            out_ovf_n   = ovf_r | add_sat;
                            out_valid_n = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_n     = ST_ACCUM;
                        acc_n       = '0;
                        cnt_n       = '0;
                        ovf_n       = 1'b0;
                        out_valid_n = 1'b0;
                    end
                end
                default: state_n = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf_r     <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            ovf_r     <= ovf_n;
            out_sum   <= out_sum_n;
            out_ovf   <= out_ovf_n;
            out_valid <= out_valid_n;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed self-checking bench for product_accumulator
module tb_product_accumulator;

    logic        clk;
    logic        rst_n;
    logic [16:0] prod [3];
    logic        valid [3];
    logic        clr [3];
    logic        ordy [3];
    logic        rdy [3];
    logic        ovld [3];
    logic        oovf [3];
    logic [19:0] sum [3];
    logic [19:0] sum0;
    logic [16:0] sum1;
    logic [19:0] sum2;

    int nchk;
    int nerr;

    typedef struct {
        int inst;
        int p0;
        int p1;
        int p2;
        int p3;
        int esum;
        int eovf;
    } vec_t;

    vec_t tbl [8];

    // u0: VEC_LEN=4 ACC_W=20, u1: VEC_LEN=4 ACC_W=17, u2: VEC_LEN=1 ACC_W=20
    product_accumulator #(.N(8), .VEC_LEN(4), .ACC_W(20)) u0 (
        .clk(clk), .rst(rst_n), .clr(clr[0]), .in_prod(prod[0]), .in_valid(valid[0]),
        .in_ready(rdy[0]), .out_sum(sum0), .out_ovf(oovf[0]), .out_valid(ovld[0]),
        .out_ready(ordy[0]));

    product_accumulator #(.N(8), .VEC_LEN(4), .ACC_W(17)) u1 (
        .clk(clk), .rst(rst_n), .clr(clr[1]), .in_prod(prod[1]), .in_valid(valid[1]),
        .in_ready(rdy[1]), .out_sum(sum1), .out_ovf(oovf[1]), .out_valid(ovld[1]),
        .out_ready(ordy[1]));

    product_accumulator #(.N(8), .VEC_LEN(1), .ACC_W(20)) u2 (
        .clk(clk), .rst(rst_n), .clr(clr[2]), .in_prod(prod[2]), .in_valid(valid[2]),
        .in_ready(rdy[2]), .out_sum(sum2), .out_ovf(oovf[2]), .out_valid(ovld[2]),
        .out_ready(ordy[2]));

    assign sum[0] = sum0;
    assign sum[1] = {3'b000, sum1};
    assign sum[2] = sum2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int i, input int p);
        valid[i] = 1'b1;
        prod[i]  = 17'(p);
        chk("ready_before_accept", 32'(rdy[i]), 1);
        tick();
    endtask

    task automatic consume(input int i);
        ordy[i] = 1'b1;
        tick();
        ordy[i] = 1'b0;
        chk("valid_after_consume", 32'(ovld[i]), 0);
        chk("ready_after_consume", 32'(rdy[i]), 1);
    endtask

    task automatic run_vec(input int i, input int p0, input int p1, input int p2,
                           input int p3, input int esum, input int eovf);
        feed(i, p0);
        feed(i, p1);
        feed(i, p2);
        chk("no_early_valid", 32'(ovld[i]), 0);
        feed(i, p3);
        valid[i] = 1'b0;
        chk("vec_valid", 32'(ovld[i]), 1);
        chk("vec_sum", 32'(sum[i]), 32'(esum));
        chk("vec_ovf", 32'(oovf[i]), 32'(eovf));
        chk("vec_hold_ready", 32'(rdy[i]), 0);
        consume(i);
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            prod[i] = '0; valid[i] = 1'b0; clr[i] = 1'b0; ordy[i] = 1'b0;
        end

        tbl[0] = '{0, 7, 7, 7, 7, 28, 0};
        tbl[1] = '{0, 65025, 65025, 65025, 65025, 260100, 0};
        tbl[2] = '{1, 65025, 65025, 65025, 65025, 131071, 1};
        tbl[3] = '{1, 1, 1, 1, 1, 4, 0};
        tbl[4] = '{1, 131071, 0, 0, 0, 131071, 0};
        tbl[5] = '{1, 131071, 1, 0, 0, 131071, 1};
        tbl[6] = '{1, 65025, 65025, 1, 0, 130051, 0};
        tbl[7] = '{0, 131071, 131071, 131071, 131071, 524284, 0};

        tick();
        chk("rst_sum", 32'(sum[0]), 0);
        chk("rst_ovf", 32'(oovf[0]), 0);
        chk("rst_valid", 32'(ovld[0]), 0);
        #2 rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(rdy[0]), 1);

        // Basic accumulate, then backpressure with in_valid held high
        run_vec(0, 1, 1, 1, 1, 4, 0);
        feed(0, 225);
        feed(0, 100);
        feed(0, 0);
        chk("basic_no_early_valid", 32'(ovld[0]), 0);
        feed(0, 65025);
        chk("basic_valid", 32'(ovld[0]), 1);
        chk("basic_sum", 32'(sum[0]), 65350);
        chk("basic_ovf", 32'(oovf[0]), 0);
        chk("basic_ready_low", 32'(rdy[0]), 0);
        valid[0] = 1'b1;
        prod[0]  = 17'd7;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_sum", 32'(sum[0]), 65350);
            chk("bp_ready", 32'(rdy[0]), 0);
            chk("bp_valid", 32'(ovld[0]), 1);
        end
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        chk("bp_handshake_valid", 32'(ovld[0]), 0);
        chk("bp_handshake_ready", 32'(rdy[0]), 1);
        chk("bp_sum_kept", 32'(sum[0]), 65350);
        for (int c = 0; c < 4; c++) tick();
        valid[0] = 1'b0;
        chk("bp_next_valid", 32'(ovld[0]), 1);
        chk("bp_next_sum", 32'(sum[0]), 28);
        consume(0);

        // clr mid-vector drops the partial sum and the same-cycle input
        feed(0, 500);
        feed(0, 600);
        clr[0] = 1'b1; valid[0] = 1'b1; prod[0] = 17'd999;
        tick();
        clr[0] = 1'b0; valid[0] = 1'b0;
        run_vec(0, 10, 20, 30, 40, 100, 0);

        // clr discards a pending result in HOLD
        run_vec(0, 2, 2, 2, 2, 8, 0);
        feed(0, 1); feed(0, 1); feed(0, 1); feed(0, 1);
        valid[0] = 1'b0;
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        chk("clr_hold_valid", 32'(ovld[0]), 0);
        chk("clr_hold_ready", 32'(rdy[0]), 1);

        for (int v = 0; v < 8; v++) begin
            run_vec(tbl[v].inst, tbl[v].p0, tbl[v].p1, tbl[v].p2, tbl[v].p3,
                    tbl[v].esum, tbl[v].eovf);
        end

        // VEC_LEN=1 with out_ready tied high and gaps between products
        ordy[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int p;
            p = (k == 0) ? 3 : (k == 1) ? 5 : 9;
            feed(2, p);
            valid[2] = 1'b0;
            chk("v1_valid", 32'(ovld[2]), 1);
            chk("v1_sum", 32'(sum[2]), 32'(p));
            chk("v1_hold_ready", 32'(rdy[2]), 0);
            tick();
            chk("v1_ready_back", 32'(rdy[2]), 1);
            chk("v1_valid_drop", 32'(ovld[2]), 0);
            tick();
            chk("v1_gap_ready", 32'(rdy[2]), 1);
        end
        ordy[2] = 1'b0;

        // Async reset while a result is held
        feed(0, 1); feed(0, 2); feed(0, 3); feed(0, 4);
        valid[0] = 1'b0;
        chk("pre_rst_valid", 32'(ovld[0]), 1);
        chk("pre_rst_sum", 32'(sum[0]), 10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(ovld[0]), 0);
        chk("async_rst_sum", 32'(sum[0]), 0);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(rdy[0]), 1);
        chk("post_rst_ovf", 32'(oovf[0]), 0);
        run_vec(0, 5, 6, 7, 8, 26, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of the n-bit shift-and-add multiplier. It consumes one (2N+1)-bit unsigned product per accepted transfer and sums VEC_LEN consecutive products into a saturating accumulator.
- It then presents the dot-product result on a valid/ready output port.
- It is the accumulate half of the sequential MAC datapath. The multiplier controller drives in_valid when a product is final.

Parameters:
- N, 8: multiplier operand width. Product width PW = 2*N+1.
- VEC_LEN, 4: products summed per result. Legal range 1 to 255.
- ACC_W, 20: accumulator and result width. Must be >= PW (elaboration error otherwise).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low. rst=0 forces reset state immediately.
- clr  in  1  synchronous abort. Discards the partial sum and any pending result.
- in_prod  in  PW  unsigned product from the multiplier.
- in_valid  in  1  in_prod is valid.
- in_ready  out  1  block can accept in_prod this cycle.
- out_sum  out  ACC_W  accumulated result.
- out_ovf  out  1  saturation occurred during this result.
- out_valid  out  1  out_sum/out_ovf valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (rst=0, async): state=ACCUM, acc=0, cnt=0, ovf_r=0, out_sum=0, out_ovf=0, out_valid=0. in_ready=1 once rst=1.
- in_ready is combinational: 1 in ACCUM, 0 in HOLD. It never depends on in_valid.
- ACCUM state:
  - Accept when in_valid & in_ready.
  - On accept: acc <= sat(acc + in_prod), cnt <= cnt+1.
  - If acc + in_prod > 2^ACC_W-1: result is all-ones and ovf_r <= 1. ovf_r stays set until the result is consumed.
  - Once saturated, further adds stay at all-ones.
- Transition ACCUM->HOLD: on the accept where cnt == VEC_LEN-1. That same edge loads out_sum with the final saturated sum and out_ovf with the final ovf (including this add), and sets out_valid=1.
  - Latency: last accept at edge t, so out_valid=1 and result visible after edge t.
  - VEC_LEN=1: every accept goes directly to HOLD.
- HOLD state: in_ready=0; in_valid is ignored and in_prod is not sampled.
  - out_sum, out_ovf and out_valid stay stable until out_valid & out_ready.
  - On that handshake edge: out_valid<=0, acc<=0, cnt<=0, ovf_r<=0, state<=ACCUM. in_ready=1 from the next cycle. No input is accepted on the handshake cycle itself.
  - out_sum/out_ovf keep their last value after out_valid falls.
- cnt width: clog2(VEC_LEN+1). It never wraps, because it is cleared on entry to ACCUM.
- clr=1 (priority over all except rst), in any state: acc=0, cnt=0, ovf_r=0, out_valid=0, state=ACCUM.
  - An in_valid on the same cycle is dropped, not accumulated.
  - A result pending in HOLD is discarded.
- rst asserted mid-operation: full reset regardless of state. There is no partial-result recovery.
- in_prod MSB is treated as data (unsigned). No check is made that it is zero.

Decomposition:
- Shared package (mac_pkg), used by both multiplier and accumulator:
  - state encoding constants ST_ACCUM=1'b0, ST_HOLD=1'b1.
  - clog2 constant function.
  - PW derivation.
- One sub-module is natural: sat_adder_nbit, a combinational ACC_W-bit unsigned saturating adder.
  - Inputs: acc and zero-extended in_prod.
  - Outputs: sum and sat flag.
- The FSM, counter and output registers live in product_accumulator.

Test Plan:
- Reset: rst low mid-HOLD with out_valid=1 -> out_valid drops immediately (async, no clock edge needed). After release: out_sum=0, out_ovf=0, in_ready=1.
- Basic accumulate (N=8, VEC_LEN=4, ACC_W=20): products 225, 100, 0, 65025 accepted back-to-back.
  - out_valid=1 the cycle after the 4th accept.
  - out_sum=65350, out_ovf=0.
  - in_ready=0 while held.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1, in_prod=7.
  - out_sum stays 65350 and stable.
  - in_ready=0 throughout; nothing accumulated.
  - After out_ready=1: next 4 accepts of 7 give out_sum=28.
- Saturation (ACC_W=17): four products of 65025.
  - out_sum=131071, out_ovf=1.
  - The next vector 1, 1, 1, 1 gives out_sum=4, out_ovf=0 (ovf cleared).
- clr mid-vector: accept 500, 600, then clr=1 with in_valid=1, in_prod=999.
  - The following 4 accepts of 10, 20, 30, 40 give out_sum=100; 999 is dropped.
- VEC_LEN=1 with gapped in_valid and out_ready tied 1:
  - Each product of 3, 5, 9 produces one result: out_sum 3, 5, 9.
  - in_ready is low exactly the one HOLD cycle after each accept.
